alu_mdu: RTL and testbench

Parametrised execution unit for the ThinPad CPU EX stage. It consumes the 4-bit ALU operation code produced by the decode-stage ALU-op decoder, with the existing codes kept unchanged. It runs logic, arithmetic, shift and compare operations in a single registered cycle, and runs unsigned multiply and divide iteratively over WIDTH cycles. A valid/ready handshake lets the pipeline stall while a multi-cycle operation is in flight.

---
 rtl/alu_mdu.sv | 205 ++++++++++++++++++++
 tb/tb_alu_mdu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage execution unit. Single-cycle ALU operations, plus an
// iterative unsigned multiply (shift-add) and divide (restoring), each taking
// WIDTH iterations. A valid/ready handshake stalls the pipeline while an
// iterative operation is in flight.
module alu_mdu #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_MULT = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;

   localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH-1:0] acc_q, acc_d;     // high product half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;       // multiplier->low product / dividend->quotient
   logic [WIDTH-1:0] opb_q, opb_d;     // multiplicand / divisor
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   logic signed [WIDTH-1:0] a_s, b_s;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] sum, diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             rem_ge;
   logic [WIDTH-1:0] it_acc, it_lo;

   assign a_s       = a;
   assign b_s       = b;
   assign shamt     = b[SHW-1:0];
   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign hi        = hi_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;

   // Single-cycle ALU result and signed-overflow flag; unknown codes act as ADD.
   always_comb begin
      sum     = a + b;
      diff    = a - b;
      alu_res = sum;
      alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      case (op)
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  begin alu_res = a & b;         alu_ovf = 1'b0; end
         OP_OR:   begin alu_res = a | b;         alu_ovf = 1'b0; end
         OP_XOR:  begin alu_res = a ^ b;         alu_ovf = 1'b0; end
         OP_NOT:  begin alu_res = ~a;            alu_ovf = 1'b0; end
         OP_SLL:  begin alu_res = a << shamt;    alu_ovf = 1'b0; end
         OP_SRL:  begin alu_res = a >> shamt;    alu_ovf = 1'b0; end
         OP_SRA:  begin alu_res = a_s >>> shamt; alu_ovf = 1'b0; end
         OP_SLT: begin
            alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            alu_ovf = 1'b0;
         end
         OP_SLTU: begin
            alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            alu_ovf = 1'b0;
         end
         default: ;
      endcase
   end

   // One multiply or divide iteration over the shared acc/lo registers.
   // A zero divisor naturally yields an all-ones quotient and remainder = a.
   always_comb begin
      mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      rem_sh  = {acc_q, lo_q[WIDTH-1]};
      rem_ge  = (rem_sh >= {1'b0, opb_q});
      rem_sub = rem_sh[WIDTH-1:0] - opb_q;
      if (is_div_q) begin
         it_acc = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
         it_lo  = {lo_q[WIDTH-2:0], rem_ge};
      end else begin
         it_acc = mul_sum[WIDTH:1];
         it_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Next-state: accept in IDLE, iterate in RUN, flush aborts without a pulse.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_div_d    = is_div_q;
      acc_d       = acc_q;
      lo_d        = lo_q;
      opb_d       = opb_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      hi_d        = hi_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               if (op == OP_MULT || op == OP_DIVU) begin
                  state_d  = RUN;
                  cnt_d    = CNT_LOAD;
                  is_div_d = (op == OP_DIVU);
                  acc_d    = '0;
                  lo_d     = a;
                  opb_d    = b;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = alu_res;
                  hi_d        = '0;
                  zero_d      = (alu_res == '0);
                  ovf_d       = alu_ovf;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               acc_d = it_acc;
               lo_d  = it_lo;
               cnt_d = cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b1;
                  result_d    = it_lo;
                  hi_d        = it_acc;
                  zero_d      = (it_lo == '0);
                  ovf_d       = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and visible outputs, cleared by the active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   // Iteration datapath; contents are don't-care outside RUN, so no reset.
   always_ff @(posedge clk) begin
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
   end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized and directed checks of alu_mdu at WIDTH 16 and 32
// against an arithmetic reference model.
module tb_alu_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        flush;
   logic        iv;
   int          W = 16;

   logic        rdy16, ov16, z16, ovf16;
   logic [15:0] res16, hi16;
   logic        rdy32, ov32, z32, ovf32;
   logic [31:0] res32, hi32;

   logic        o_rdy, o_ov, o_z, o_ovf;
   logic [31:0] o_res, o_hi;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_mdu #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv && (W == 16)), .in_ready(rdy16),
      .op(op), .a(a[15:0]), .b(b[15:0]), .flush(flush),
      .out_valid(ov16), .result(res16), .hi(hi16), .zero(z16), .ovf(ovf16)
   );

   alu_mdu #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv && (W == 32)), .in_ready(rdy32),
      .op(op), .a(a), .b(b), .flush(flush),
      .out_valid(ov32), .result(res32), .hi(hi32), .zero(z32), .ovf(ovf32)
   );

   always_comb begin
      if (W == 16) begin
         o_rdy = rdy16; o_ov = ov16; o_z = z16; o_ovf = ovf16;
         o_res = {16'h0, res16}; o_hi = {16'h0, hi16};
      end else begin
         o_rdy = rdy32; o_ov = ov32; o_z = z32; o_ovf = ovf32;
         o_res = res32; o_hi = hi32;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s (W=%0d) got=%0h expected=%0h", tag, W, got, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input int w);
      return (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
   endfunction

   // Reference: result/hi/ovf from plain arithmetic on the operation's meaning.
   function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input int w, output logic [31:0] r, output logic [31:0] h,
                                 output logic v);
      logic [31:0] m;
      logic [63:0] xs, ys, p, t;
      int          sh;
      m  = wmask(w);
      xs = x[w-1] ? {32'hFFFF_FFFF, x | ~m} : {32'h0, x};
      ys = y[w-1] ? {32'hFFFF_FFFF, y | ~m} : {32'h0, y};
      sh = int'(y) & (w - 1);
      r = '0; h = '0; v = 1'b0;
      case (o)
         4'd1: begin r = (x - y) & m; v = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]); end
         4'd2: r = x & y;
         4'd3: r = x | y;
         4'd4: r = x ^ y;
         4'd5: r = ~x & m;
         4'd6: r = (x << sh) & m;
         4'd7: r = x >> sh;
         4'd8: begin t = $signed(xs) >>> sh; r = t[31:0] & m; end
         4'd9: r = ($signed(xs) < $signed(ys)) ? 32'd1 : 32'd0;
         4'd10: r = (x < y) ? 32'd1 : 32'd0;
         4'd11: begin
            p = {32'h0, x} * {32'h0, y};
            r = p[31:0] & m;
            t = p >> w;
            h = t[31:0] & m;
         end
         4'd12: begin
            if (y == 0) begin r = m; h = x; end
            else begin r = x / y; h = x % y; end
         end
         default: begin r = (x + y) & m; v = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]); end
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] o, input logic [31:0] x,
                                input logic [31:0] y);
      logic [31:0] r, h;
      logic        v;
      model(o, x, y, W, r, h, v);
      check({tag, "_res"},  o_res, r);
      check({tag, "_hi"},   o_hi, h);
      check({tag, "_zero"}, o_z, (r == 0));
      check({tag, "_ovf"},  o_ovf, v);
   endtask

   // Present one single-cycle op for one edge; leaves in_valid high so the
   // caller may issue back-to-back.
   task automatic run_single(input string tag, input logic [3:0] o, input logic [31:0] x,
                             input logic [31:0] y);
      op = o; a = x & wmask(W); b = y & wmask(W); iv = 1'b1;
      step();
      check({tag, "_vld"}, o_ov, 1'b1);
      check_outputs(tag, o, a, b);
   endtask

   // Issue MULT/DIVU, hold in_valid while busy, measure busy span and pulse.
   task automatic run_multi(input string tag, input logic [3:0] o, input logic [31:0] x,
                            input logic [31:0] y);
      int n = 0;
      int early = 0;
      logic [31:0] xa, ya;
      xa = x & wmask(W); ya = y & wmask(W);
      op = o; a = xa; b = ya; iv = 1'b1;
      step();
      while (o_rdy == 1'b0 && n < W + 8) begin
         if (o_ov) early++;
         step();
         n++;
      end
      iv = 1'b0;
      check({tag, "_busy"}, n, W);
      check({tag, "_early"}, early, 0);
      check({tag, "_vld"}, o_ov, 1'b1);
      check_outputs(tag, o, xa, ya);
      step();
      check({tag, "_pulse"}, o_ov, 1'b0);
   endtask

   task automatic run_suite();
      logic [31:0] m, msb, pr, ph;
      logic        pz, pv;
      logic [3:0]  ro;
      m   = wmask(W);
      msb = 32'h1 << (W - 1);

      rst = 1'b0; iv = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      step(); step();
      check("rst_vld", o_ov, 1'b0);
      check("rst_res", o_res, 0);
      check("rst_hi", o_hi, 0);
      check("rst_zero", o_z, 1'b0);
      check("rst_ovf", o_ovf, 1'b0);
      check("rst_rdy", o_rdy, 1'b1);
      rst = 1'b1;

      run_single("add_ovf", 4'd0, msb - 1, 1);
      check("add_ovf_exact", o_res, msb);
      iv = 1'b0; step();

      run_single("sra", 4'd8, msb, 4);
      run_single("srl", 4'd7, msb, 4);
      run_single("sll", 4'd6, 1, W - 1);
      run_single("slt", 4'd9, m, 1);
      run_single("sltu", 4'd10, m, 1);
      run_single("sub0", 4'd1, 5, 5);
      run_single("sra0", 4'd8, msb | 32'h5, 0);
      run_single("op15", 4'd15, 3, 9);
      iv = 1'b0; step();
      check("idle_vld", o_ov, 1'b0);

      run_multi("mul1", 4'd11, 32'h1234, 32'h10);
      run_multi("mul2", 4'd11, m, m);
      run_multi("div1", 4'd12, 100, 7);
      run_multi("div0", 4'd12, 32'h1234, 0);

      // flush while idle blocks acceptance and leaves outputs held
      pr = o_res;
      op = 4'd0; a = 1; b = 1; iv = 1'b1; flush = 1'b1;
      step();
      iv = 1'b0; flush = 1'b0;
      check("iflush_vld", o_ov, 1'b0);
      check("iflush_hold", o_res, pr);

      // flush in RUN after 5 iterations
      pr = o_res; ph = o_hi; pz = o_z; pv = o_ovf;
      op = 4'd11; a = 32'h1234 & m; b = 32'h10; iv = 1'b1;
      step();
      iv = 1'b0;
      repeat (5) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("rflush_vld", o_ov, 1'b0);
      check("rflush_rdy", o_rdy, 1'b1);
      check("rflush_res", o_res, pr);
      check("rflush_hi", o_hi, ph);
      check("rflush_zero", o_z, pz);
      check("rflush_ovf", o_ovf, pv);
      run_single("add34", 4'd0, 3, 4);
      iv = 1'b0; step();

      // reset in the middle of a divide
      op = 4'd12; a = 100; b = 7; iv = 1'b1;
      step();
      iv = 1'b0;
      repeat (7) step();
      rst = 1'b0;
      step();
      check("mrst_vld", o_ov, 1'b0);
      check("mrst_res", o_res, 0);
      check("mrst_hi", o_hi, 0);
      check("mrst_zero", o_z, 1'b0);
      check("mrst_rdy", o_rdy, 1'b1);
      rst = 1'b1;
      run_multi("post_rst_div", 4'd12, 1000, 33);

      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         if (ro == 4'd11 || ro == 4'd12)
            run_multi("rnd_md", ro, $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
         else
            run_single("rnd_alu", ro, $urandom, ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      end
      iv = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b0; iv = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
      W = 16;
      run_suite();
      W = 32;
      run_suite();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
